// File: rtl/ser_pkg.sv
// Shared types and defaults for the MSB-first word serializer.
package ser_pkg;

  typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_e;

  localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/word_serializer_msb_if.sv
// Word-in / bit-out bundle between the upstream word source and the serializer.
import ser_pkg::*;

interface word_serializer_msb_if #(
  parameter int WIDTH = SER_DEFAULT_WIDTH,
  parameter int CNT_W = 16
);
  logic             flush_i;
  logic             word_valid_i;
  logic [WIDTH-1:0] word_i;
  logic             word_ready_o;
  logic             bit_o;
  logic             bit_valid_o;
  logic             first_o;
  logic             last_o;
  logic [CNT_W-1:0] word_cnt_o;

  modport slave (
    input  flush_i, word_valid_i, word_i,
    output word_ready_o, bit_o, bit_valid_o, first_o, last_o, word_cnt_o
  );

  modport master (
    output flush_i, word_valid_i, word_i,
    input  word_ready_o, bit_o, bit_valid_o, first_o, last_o, word_cnt_o
  );
endinterface

// File: rtl/word_serializer_msb.sv
// Parallel-to-serial front end: WIDTH-bit words out MSB-first, one bit per clk.
// Latency 1 clk from accept to MSB; ready only when idle or on the LSB cycle, so words chain with no gap.
import ser_pkg::*;

module word_serializer_msb #(
  parameter int WIDTH = SER_DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  word_serializer_msb_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  ser_state_e       state;
  ser_state_e       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] word_cnt;
  logic             at_last;
  logic             ready;
  logic             accept;

  assign at_last = (state == SER_SHIFT) && (idx == IDX_LAST);

  always_comb begin
    state_nxt        = state;
    ready            = 1'b0;
    accept           = 1'b0;
    bus.bit_o        = 1'b0;
    bus.bit_valid_o  = 1'b0;
    bus.first_o      = 1'b0;
    bus.last_o       = 1'b0;

    // Ready depends only on registered state and flush, never on word_valid_i.
    ready  = !bus.flush_i && ((state == SER_IDLE) || at_last);
    accept = ready && bus.word_valid_i;

    if (state == SER_SHIFT) begin
      bus.bit_o       = shreg[WIDTH-1];
      bus.bit_valid_o = 1'b1;
      bus.first_o     = (idx == '0);
      bus.last_o      = at_last;
    end

    if (bus.flush_i) begin
      state_nxt = SER_IDLE;
    end else if (accept) begin
      state_nxt = SER_SHIFT;
    end else if (at_last) begin
      state_nxt = SER_IDLE;
    end

    bus.word_ready_o = ready;
  end

  assign bus.word_cnt_o = word_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SER_IDLE;
      shreg    <= '0;
      idx      <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (bus.flush_i) begin
        // The word in flight is dropped and never counted.
        shreg <= '0;
        idx   <= '0;
      end else begin
        if (at_last) begin
          word_cnt <= word_cnt + 1'b1;
        end
        if (accept) begin
          shreg <= bus.word_i;
          idx   <= '0;
        end else if (state == SER_SHIFT) begin
          shreg <= shreg << 1;
          idx   <= at_last ? '0 : idx + 1'b1;
        end
      end
    end
  end

endmodule
